rd_burst_prefetch: RTL and testbench

- Chip-side consumer of one async read FIFO (SPI read channel). Sits between the read FIFO's chip-domain interface and the core's dataflow arbiter.
- On a config pulse it issues a credit-limited burst of single-word read requests to the FIFO and buffers the returned words in a local FIFO.
- Presents the words to the core as a valid/ready stream, with last and tag sidebands.

---
 rtl/rd_burst_prefetch.sv | 165 ++++++++++++++++
 tb/tb_rd_burst_prefetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_burst_prefetch.sv
// rd_burst_prefetch
//   Chip-side consumer of the SPI read-channel async FIFO. A config pulse
//   starts a burst of L = (cfg_data_i+1)*BURST_UNIT single-word read
//   requests. Requests are credit-limited so that returned words always fit
//   in the local buffer. Buffered words are presented to the core as a
//   valid/ready stream with last/tag sidebands.
//
//   Optional feature (macro RDBUF_BYPASS_EN): when the buffer is empty, a
//   returning word is presented combinationally in the same cycle. If it is
//   accepted that cycle it never touches the buffer.
//
// Ports
//   clk_chip, reset_n_chip      : clock, async active-low reset
//   cfg_pulse_i / cfg_data_i    : burst start, length code / tag
//   cfg_ready_o                 : idle, can take a new burst
//   rd_req_o                    : one-word read request pulse to the FIFO
//   rd_valid_i / rd_data_i      : returned word from the FIFO
//   out_valid_o / out_ready_i   : stream handshake to the core
//   out_data_o, out_last_o      : stream data, final word of the burst
//   out_tag_o                   : cfg_data_i latched for the current burst
//   busy_o                      : burst in progress
//   err_o                       : sticky; set by a cfg pulse while busy or
//                                 by a return with nothing outstanding
module rd_burst_prefetch #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int BURST_UNIT = 4,
  parameter int CFG_WIDTH  = 4
) (
  input  logic                  clk_chip,
  input  logic                  reset_n_chip,
  input  logic                  cfg_pulse_i,
  input  logic [CFG_WIDTH-1:0]  cfg_data_i,
  output logic                  cfg_ready_o,
  output logic                  rd_req_o,
  input  logic                  rd_valid_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic [CFG_WIDTH-1:0]  out_tag_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int OW   = AW + 1;                       // occupancy / outstanding
  localparam int MAXL = (1 << CFG_WIDTH) * BURST_UNIT;
  localparam int CW   = $clog2(MAXL + 1);             // burst counters
  localparam logic [OW:0] LIM = (OW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_req_left, r_word_left;
  logic [OW-1:0]         r_outst, r_occ;
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CFG_WIDTH-1:0]  r_tag;
  logic                  r_err;

  logic                  w_empty, w_credit_ok, w_rd_req, w_accept, w_spur;
  logic                  w_byp, w_out_valid, w_fire, w_last, w_push, w_pop;
  logic                  w_cfg_ok;
  logic [OW:0]           w_inflight;
  logic [CW-1:0]         w_len;
  logic [DATA_WIDTH-1:0] w_out_data;

  assign w_empty     = (r_occ == '0);
  // Words already buffered plus words still in flight must never exceed the
  // buffer size; this is what keeps any return latency overflow-free.
  assign w_inflight  = {1'b0, r_occ} + {1'b0, r_outst};
  assign w_credit_ok = (w_inflight < LIM);
  assign w_rd_req    = (r_state == S_ACTIVE) && (r_req_left != '0) && w_credit_ok;

  // A return with nothing outstanding is spurious: dropped and flagged.
  assign w_accept    = rd_valid_i && (r_outst != '0);
  assign w_spur      = rd_valid_i && (r_outst == '0);

`ifdef RDBUF_BYPASS_EN
  assign w_byp       = w_empty && w_accept;
`else
  assign w_byp       = 1'b0;
`endif

  assign w_out_valid = !w_empty || w_byp;
  assign w_out_data  = !w_empty ? r_mem[r_rptr] : (w_byp ? rd_data_i : '0);
  assign w_fire      = w_out_valid && out_ready_i;
  assign w_last      = w_out_valid && (r_word_left == CW'(1));
  assign w_pop       = w_fire && !w_empty;
  // A bypassed word taken in its arrival cycle skips the buffer entirely.
  assign w_push      = w_accept && !(w_byp && out_ready_i);

  assign w_cfg_ok    = cfg_pulse_i && (r_state == S_IDLE);
  assign w_len       = CW'((int'(cfg_data_i) + 1) * BURST_UNIT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cfg_pulse_i) w_state_nxt = S_ACTIVE;
      // Leave ACTIVE in the cycle the final request goes out.
      S_ACTIVE: if (w_rd_req && (r_req_left == CW'(1))) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_fire && w_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) begin
      r_state     <= S_IDLE;
      r_req_left  <= '0;
      r_word_left <= '0;
      r_outst     <= '0;
      r_occ       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_tag       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_cfg_ok) begin
        r_tag       <= cfg_data_i;
        r_req_left  <= w_len;
        r_word_left <= w_len;
      end else begin
        if (w_rd_req) r_req_left  <= r_req_left - CW'(1);
        if (w_fire)   r_word_left <= r_word_left - CW'(1);
      end

      case ({w_rd_req, w_accept})
        2'b10:   r_outst <= r_outst + OW'(1);
        2'b01:   r_outst <= r_outst - OW'(1);
        default: ;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: ;
      endcase

      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);

      if (w_spur || (cfg_pulse_i && (r_state != S_IDLE))) r_err <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clk_chip) begin
    if (w_push) r_mem[r_wptr] <= rd_data_i;
  end

  assign cfg_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign rd_req_o    = w_rd_req;
  assign out_valid_o = w_out_valid;
  assign out_data_o  = w_out_data;
  assign out_last_o  = w_last;
  assign out_tag_o   = r_tag;
  assign err_o       = r_err;

endmodule

// File: tb/tb_rd_burst_prefetch.sv
// Directed bench for rd_burst_prefetch. A queue-based behavioural model of
// the burst/credit/stream rules predicts every output each cycle; a FIFO
// stub answers each request after a fixed latency with sequential words.
// Literal expectations per scenario pin request counts, data order, last
// position, first-word latency and the error/reset behaviour.
module tb_rd_burst_prefetch;
  localparam int DW = 32, DEPTH = 8, BU = 4, CFW = 4;
`ifdef RDBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int FIRST_LAT = 2;
`else
  localparam bit BYP = 1'b0;
  localparam int FIRST_LAT = 3;
`endif

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           cfg_pulse = 1'b0;
  logic [CFW-1:0] cfg_data = '0;
  logic           cfg_ready, rd_req, rd_valid = 1'b0;
  logic [DW-1:0]  rd_data = '0;
  logic           out_valid, out_ready = 1'b0;
  logic [DW-1:0]  out_data;
  logic           out_last, busy, err;
  logic [CFW-1:0] out_tag;

  always #5 clk = ~clk;

  rd_burst_prefetch #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_UNIT(BU), .CFG_WIDTH(CFW)) dut (
    .clk_chip(clk), .reset_n_chip(rst_n),
    .cfg_pulse_i(cfg_pulse), .cfg_data_i(cfg_data), .cfg_ready_o(cfg_ready),
    .rd_req_o(rd_req), .rd_valid_i(rd_valid), .rd_data_i(rd_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .out_tag_o(out_tag), .busy_o(busy), .err_o(err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // behavioural model
  bit             m_busy, m_err;
  int             m_reqleft, m_wordleft, m_outst;
  logic [DW-1:0]  m_buf[$];
  logic [CFW-1:0] m_tag;

  // FIFO stub and observations
  int             ret_due[$];
  logic [DW-1:0]  ret_dat[$];
  int             lat = 1, cyc = 0, rdy_mode = 0;
  bit             spur = 1'b0;
  logic [DW-1:0]  next_word = '0;
  logic [DW-1:0]  got[$];
  int             last_idx[$];
  int             req_cnt = 0, first_out_cyc = -1, cfg_cyc = 0, max_infl = 0;

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_reqleft = 0; m_wordleft = 0; m_outst = 0;
    m_buf.delete(); m_tag = '0;
    ret_due.delete(); ret_dat.delete();
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step();
    logic          e_req, e_val, e_last, acc;
    logic [DW-1:0] e_dat;
    bit            was_busy, byp_used;
    rd_valid = 1'b0; rd_data = '0;
    if (ret_due.size() > 0 && ret_due[0] == cyc) begin
      rd_valid = 1'b1; rd_data = ret_dat[0];
      void'(ret_due.pop_front()); void'(ret_dat.pop_front());
    end else if (spur) begin
      rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
    end
    if (rdy_mode == 1) out_ready = (cyc % 3 != 0);
    #2;
    if (req_cnt - got.size() > max_infl) max_infl = req_cnt - got.size();

    e_req  = m_busy && m_reqleft > 0 && (m_buf.size() + m_outst < DEPTH);
    acc    = rd_valid && m_outst > 0;
    e_val  = m_buf.size() > 0 || (BYP && acc);
    e_dat  = m_buf.size() > 0 ? m_buf[0] : (e_val ? rd_data : '0);
    e_last = e_val && m_wordleft == 1;
    chk("cfg_ready", cfg_ready, !m_busy);
    chk("busy",      busy,      m_busy);
    chk("rd_req",    rd_req,    e_req);
    chk("out_valid", out_valid, e_val);
    chk("out_data",  out_data,  e_dat);
    chk("out_last",  out_last,  e_last);
    chk("out_tag",   out_tag,   m_tag);
    chk("err",       err,       m_err);

    if (out_valid && out_ready) begin
      if (got.size() == 0) first_out_cyc = cyc;
      if (out_last) last_idx.push_back(got.size());
      got.push_back(out_data);
    end
    if (rd_req) begin
      ret_due.push_back(cyc + lat); ret_dat.push_back(next_word);
      next_word++; req_cnt++;
    end

    was_busy = m_busy;
    byp_used = BYP && acc && (m_buf.size() == 0) && out_ready;
    if ((rd_valid && m_outst == 0) || (cfg_pulse && was_busy)) m_err = 1;
    if (e_val && out_ready) begin
      if (m_buf.size() > 0) void'(m_buf.pop_front());
      m_wordleft--;
      if (e_last) m_busy = 0;
    end
    if (acc) begin
      m_outst--;
      if (!byp_used) m_buf.push_back(rd_data);
    end
    if (e_req) begin m_reqleft--; m_outst++; end
    if (cfg_pulse && !was_busy) begin
      m_busy = 1; m_tag = cfg_data;
      m_reqleft = (int'(cfg_data) + 1) * BU; m_wordleft = m_reqleft;
    end

    @(posedge clk); #1;
    cyc++;
    cfg_pulse = 1'b0; spur = 1'b0;
  endtask

  task automatic start_burst(input logic [CFW-1:0] code);
    got.delete(); last_idx.delete();
    req_cnt = 0; max_infl = 0; first_out_cyc = -1; cfg_cyc = cyc;
    cfg_data = code; cfg_pulse = 1'b1;
    step();
  endtask

  task automatic run_idle(input int limit);
    int n = 0;
    while ((m_busy || ret_due.size() > 0) && n < limit) begin step(); n++; end
    chk("burst_completes_in_budget", n < limit, 1);
  endtask

  task automatic chk_seq(input string nm, input logic [DW-1:0] base, input int len);
    chk({nm, "_count"}, got.size(), len);
    for (int i = 0; i < got.size() && i < len; i++) chk({nm, "_word"}, got[i], base + i);
    chk({nm, "_last_count"}, last_idx.size(), 1);
    if (last_idx.size() > 0) chk({nm, "_last_pos"}, last_idx[0], len - 1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_cfg_ready"}, cfg_ready, 1);
    chk({nm, "_busy"},      busy,      0);
    chk({nm, "_rd_req"},    rd_req,    0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_data"},  out_data,  0);
    chk({nm, "_out_last"},  out_last,  0);
    chk({nm, "_out_tag"},   out_tag,   0);
    chk({nm, "_err"},       err,       0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    #2;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic burst: L=4, latency 1, always ready
    next_word = 32'hA0; lat = 1; out_ready = 1'b1;
    start_burst(4'd0);
    run_idle(50);
    chk("basic_req_count", req_cnt, 4);
    chk_seq("basic", 32'hA0, 4);
    chk("basic_first_latency", first_out_cyc - cfg_cyc, FIRST_LAT);
    chk("basic_cfg_ready_after", cfg_ready, 1);

    // backpressure: L=16, ready low -> credit stops at DEPTH requests
    next_word = 32'hB0; out_ready = 1'b0;
    start_burst(4'd3);
    repeat (30) step();
    chk("bp_req_count", req_cnt, 8);
    chk("bp_req_stalled", rd_req, 0);
    out_ready = 1'b1;
    run_idle(100);
    chk_seq("bp", 32'hB0, 16);
    chk("bp_err", err, 0);

    // long return latency with intermittent ready
    next_word = 32'h100; lat = 5; rdy_mode = 1;
    start_burst(4'd3);
    run_idle(300);
    rdy_mode = 0; out_ready = 1'b1;
    chk("lat_inflight_le_depth", max_infl <= DEPTH, 1);
    chk("lat_inflight_reached", max_infl >= 5, 1);
    chk_seq("lat", 32'h100, 16);

    // errors: cfg while busy, then spurious return in idle
    next_word = 32'h200; lat = 2;
    start_burst(4'd2);
    repeat (3) step();
    chk("err_before", err, 0);
    cfg_data = 4'hF; cfg_pulse = 1'b1;
    step();
    chk("err_after_cfg_busy", err, 1);
    chk("err_tag_kept", out_tag, 2);
    run_idle(100);
    chk_seq("err", 32'h200, 12);
    spur = 1'b1;
    step();
    chk("err_sticky", err, 1);
    chk("err_spur_dropped", out_valid, 0);
    chk("err_tag_after", out_tag, 2);

    // reset mid-burst after 3 of 8 words
    next_word = 32'h300; lat = 1;
    start_burst(4'd1);
    n = 0;
    while (got.size() < 3 && n < 50) begin step(); n++; end
    chk("rst_words_before", got.size(), 3);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    model_reset();
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b1;
    next_word = 32'h3C0;
    start_burst(4'd1);
    run_idle(60);
    chk_seq("rst_next", 32'h3C0, 8);
    chk("rst_next_tag", out_tag, 1);
    chk("rst_next_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
